// File: rtl/tilelink_arbiter_2x1.sv
// TileLink-UL 2-host to 1-device arbiter with one outstanding transaction,
// round-robin host selection, and a response timeout that makes the block
// answer the host itself with an error.
package tilelink_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
endpackage

module tilelink_arbiter_2x1
  import tilelink_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      clock,
  input  logic      reset,
  input  tilelink_a h0_tla,
  output logic      h0_a_ready,
  output tilelink_d h0_tld,
  input  logic      h0_d_ready,
  input  tilelink_a h1_tla,
  output logic      h1_a_ready,
  output tilelink_d h1_tld,
  input  logic      h1_d_ready,
  output tilelink_a dev_tla,
  input  logic      dev_a_ready,
  input  tilelink_d dev_tld,
  output logic      dev_d_ready,
  output logic      busy,
  output logic      stale_drop
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e    state_q;
  logic      last_grant_q;
  logic      grant_q;
  logic [7:0] tmo_q;
  tilelink_a a_lat_q;

  logic      any_valid;
  logic      win;
  logic      gnt_d_ready;
  logic      d_fire;
  tilelink_d rsp_tld;
  tilelink_d err_tld;

  // Arbitration winner, handshake qualifiers and the two possible host responses
  always_comb begin
    any_valid   = h0_tla.a_valid | h1_tla.a_valid;
    // Both valid: the host not served last wins; otherwise the lone requester.
    win         = (h0_tla.a_valid & h1_tla.a_valid) ? ~last_grant_q : h1_tla.a_valid;
    gnt_d_ready = grant_q ? h1_d_ready : h0_d_ready;
    d_fire      = dev_tld.d_valid & gnt_d_ready;

    rsp_tld         = dev_tld;
    rsp_tld.d_ready = 1'b0;

    err_tld          = '0;
    err_tld.d_valid  = 1'b1;
    err_tld.d_error  = 1'b1;
    err_tld.d_size   = a_lat_q.a_size;
    err_tld.d_source = a_lat_q.a_source;
    err_tld.d_opcode = (a_lat_q.a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
  end

  // Transaction FSM: grant, forward A, wait for D or time out
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      tmo_q        <= '0;
      a_lat_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_lat_q      <= win ? h1_tla : h0_tla;
            grant_q      <= win;
            last_grant_q <= win;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (dev_a_ready) begin
            tmo_q   <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (d_fire) begin
            tmo_q   <= '0;
            state_q <= IDLE;
          end else if (tmo_q + 8'd1 == TMO_LIMIT) begin
            tmo_q   <= '0;
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        ERR: begin
          if (gnt_d_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output steering by state
  always_comb begin
    h0_a_ready  = (state_q == IDLE) & h0_tla.a_valid & ~win;
    h1_a_ready  = (state_q == IDLE) & h1_tla.a_valid & win;
    h0_tld      = '0;
    h1_tld      = '0;
    dev_d_ready = 1'b1;
    stale_drop  = 1'b0;
    busy        = (state_q != IDLE);

    dev_tla         = a_lat_q;
    dev_tla.a_valid = (state_q == REQ);
    dev_tla.a_ready = 1'b0;

    case (state_q)
      REQ: dev_d_ready = 1'b0;
      RESP: begin
        dev_d_ready = gnt_d_ready;
        if (grant_q) h1_tld = rsp_tld;
        else         h0_tld = rsp_tld;
      end
      ERR: begin
        stale_drop = dev_tld.d_valid;
        if (grant_q) h1_tld = err_tld;
        else         h0_tld = err_tld;
      end
      default: stale_drop = dev_tld.d_valid;
    endcase
  end

endmodule

// File: tb/tb_tilelink_arbiter_2x1.sv
// Bench for tilelink_arbiter_2x1: cycle table, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_tilelink_arbiter_2x1;
  import tilelink_pkg::*;

  localparam int unsigned TO = 4;

  logic      clk;
  logic      rst;
  tilelink_a h0_tla, h1_tla, dev_tla;
  tilelink_d h0_tld, h1_tld, dev_tld;
  logic      h0_a_ready, h1_a_ready, h0_d_ready, h1_d_ready;
  logic      dev_a_ready, dev_d_ready, busy, stale_drop;

  int checks;
  int failures;

  tilelink_arbiter_2x1 #(.TIMEOUT_CYCLES(TO)) dut (
    .clock      (clk),
    .reset      (rst),
    .h0_tla     (h0_tla),
    .h0_a_ready (h0_a_ready),
    .h0_tld     (h0_tld),
    .h0_d_ready (h0_d_ready),
    .h1_tla     (h1_tla),
    .h1_a_ready (h1_a_ready),
    .h1_tld     (h1_tld),
    .h1_d_ready (h1_d_ready),
    .dev_tla    (dev_tla),
    .dev_a_ready(dev_a_ready),
    .dev_tld    (dev_tld),
    .dev_d_ready(dev_d_ready),
    .busy       (busy),
    .stale_drop (stale_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    h0_tla = '0; h1_tla = '0; dev_tld = '0;
    h0_d_ready = 1'b0; h1_d_ready = 1'b0; dev_a_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic tilelink_a mk_a(input logic v, input logic [2:0] op, input logic [7:0] src,
                                     input logic [31:0] addr, input logic [31:0] data);
    tilelink_a a;
    a = '0;
    a.a_valid = v; a.a_opcode = op; a.a_size = 2'd2; a.a_source = src;
    a.a_address = addr; a.a_mask = 4'hf; a.a_data = data;
    return a;
  endfunction

  function automatic tilelink_a rand_a();
    tilelink_a a;
    a.a_valid   = 1'($urandom_range(0, 1));
    a.a_opcode  = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
    a.a_param   = 3'($urandom_range(0, 7));
    a.a_size    = 2'($urandom_range(0, 3));
    a.a_source  = 8'($urandom_range(0, 255));
    a.a_address = $urandom;
    a.a_mask    = 4'($urandom_range(0, 15));
    a.a_data    = $urandom;
    a.a_ready   = 1'($urandom_range(0, 1));
    return a;
  endfunction

  function automatic tilelink_d rand_d();
    tilelink_d d;
    d.d_valid  = ($urandom_range(0, 9) < 3);
    d.d_opcode = 3'($urandom_range(0, 7));
    d.d_param  = 3'($urandom_range(0, 7));
    d.d_size   = 2'($urandom_range(0, 3));
    d.d_source = 8'($urandom_range(0, 255));
    d.d_sink   = 1'($urandom_range(0, 1));
    d.d_data   = $urandom;
    d.d_error  = 1'($urandom_range(0, 1));
    d.d_ready  = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Error response a host must see for a given accepted request
  function automatic tilelink_d err_of(input tilelink_a a);
    tilelink_d d;
    d = '0;
    d.d_valid = 1'b1; d.d_error = 1'b1;
    d.d_size = a.a_size; d.d_source = a.a_source;
    d.d_opcode = (a.a_opcode == 3'd4) ? 3'd1 : 3'd0;
    return d;
  endfunction

  function automatic tilelink_a fwd_of(input tilelink_a a);
    tilelink_a r;
    r = a; r.a_valid = 1'b1; r.a_ready = 1'b0;
    return r;
  endfunction

  // Cycle table: inputs {v0 v1 dar ddv r0 r1}, outputs {ar0 ar1 dav ddr dv0 dv1 busy sd}
  typedef struct packed {
    logic [5:0] in;
    logic [7:0] ex;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [5:0] in, input logic [7:0] ex);
    vec_t v;
    v.in = in; v.ex = ex;
    tbl.push_back(v);
  endtask

  // Reference model state (transaction level)
  logic      m_active, m_gnt, m_last, m_issued;
  int        m_waits;
  tilelink_a m_pay;

  initial begin
    tilelink_a pa, e_a;
    tilelink_d pd, e_d;
    logic [7:0] got;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle_inputs();

    // ---- reset state ----
    reset_dut();
    #1;
    chk("rst_h0_a_ready", 128'(h0_a_ready), 128'(1'b0));
    chk("rst_h1_a_ready", 128'(h1_a_ready), 128'(1'b0));
    chk("rst_h0_tld", 128'(h0_tld), 128'(0));
    chk("rst_h1_tld", 128'(h1_tld), 128'(0));
    chk("rst_dev_tla", 128'(dev_tla), 128'(0));
    chk("rst_dev_d_ready", 128'(dev_d_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_stale_drop", 128'(stale_drop), 128'(1'b0));

    // ---- cycle table: arbitration, REQ/RESP handshakes, stale drop ----
    add(6'b110000, 8'b10010000); // both Get after reset: h0 wins
    add(6'b010000, 8'b00100010); // REQ, forward to device
    add(6'b011000, 8'b00100010); // device accepts
    add(6'b010100, 8'b00001010); // RESP, h0 not ready: held, dev_d_ready 0
    add(6'b010110, 8'b00011010); // D handshake to h0
    add(6'b010000, 8'b01010000); // h1 granted next
    add(6'b101000, 8'b00100010); // REQ accepted
    add(6'b100101, 8'b00010110); // D handshake to h1 only
    add(6'b000100, 8'b00010001); // stray beat in IDLE
    add(6'b000000, 8'b00010000);
    add(6'b110000, 8'b10010000); // last grant h1 -> h0 wins
    add(6'b111000, 8'b00100010);
    add(6'b110110, 8'b00011010);
    add(6'b110000, 8'b01010000); // last grant h0 -> h1 wins
    h0_tla = mk_a(1'b0, 3'd4, 8'd1, 32'h100, 32'h0);
    h1_tla = mk_a(1'b0, 3'd4, 8'd2, 32'h200, 32'h0);
    dev_tld = '0;
    dev_tld.d_opcode = 3'd1; dev_tld.d_data = 32'h1234_5678;
    for (int unsigned i = 0; i < tbl.size(); i++) begin
      {h0_tla.a_valid, h1_tla.a_valid, dev_a_ready, dev_tld.d_valid, h0_d_ready, h1_d_ready} = tbl[i].in;
      #1;
      got = {h0_a_ready, h1_a_ready, dev_tla.a_valid, dev_d_ready,
             h0_tld.d_valid, h1_tld.d_valid, busy, stale_drop};
      chk($sformatf("table_row%0d", i), 128'(got), 128'(tbl[i].ex));
      tick();
    end

    // ---- h1 PutFullData with device back-pressure ----
    reset_dut();
    pa = mk_a(1'b1, 3'd0, 8'd5, 32'h10, 32'hDEADBEEF);
    h1_tla = pa;
    #1;
    chk("put_h1_a_ready", 128'(h1_a_ready), 128'(1'b1));
    tick();
    h1_tla.a_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      dev_a_ready = (i == 3);
      #1;
      chk($sformatf("put_dev_tla_c%0d", i), 128'(dev_tla), 128'(fwd_of(pa)));
      tick();
    end
    dev_a_ready = 1'b0;
    pd = '0;
    pd.d_valid = 1'b1; pd.d_opcode = 3'd0; pd.d_size = 2'd2; pd.d_source = 8'd5; pd.d_ready = 1'b1;
    dev_tld = pd;
    h0_d_ready = 1'b1; h1_d_ready = 1'b1;
    #1;
    e_d = pd; e_d.d_ready = 1'b0;
    chk("put_h1_tld", 128'(h1_tld), 128'(e_d));
    chk("put_h0_d_valid", 128'(h0_tld.d_valid), 128'(1'b0));
    chk("put_dev_d_ready", 128'(dev_d_ready), 128'(1'b1));
    tick();
    idle_inputs();
    #1;
    chk("put_done_busy", 128'(busy), 128'(1'b0));

    // ---- timeout to ERR, synthesized response, late beat ----
    reset_dut();
    pa = mk_a(1'b1, 3'd4, 8'd3, 32'h40, 32'h0);
    h0_tla = pa;
    #1;
    chk("tmo_h0_a_ready", 128'(h0_a_ready), 128'(1'b1));
    tick();
    h0_tla.a_valid = 1'b0;
    dev_a_ready = 1'b1;
    tick();
    dev_a_ready = 1'b0;
    for (int unsigned i = 0; i < TO; i++) begin
      #1;
      chk($sformatf("tmo_resp_ddr_c%0d", i), 128'(dev_d_ready), 128'(1'b0));
      chk($sformatf("tmo_resp_dv_c%0d", i), 128'(h0_tld.d_valid), 128'(1'b0));
      tick();
    end
    #1;
    chk("tmo_err_h0_tld", 128'(h0_tld), 128'(err_of(pa)));
    chk("tmo_err_ddr", 128'(dev_d_ready), 128'(1'b1));
    chk("tmo_err_busy", 128'(busy), 128'(1'b1));
    tick();
    dev_tld.d_valid = 1'b1;
    #1;
    chk("tmo_err_stale", 128'(stale_drop), 128'(1'b1));
    chk("tmo_err_h0_hold", 128'(h0_tld), 128'(err_of(pa)));
    chk("tmo_err_h1_dv", 128'(h1_tld.d_valid), 128'(1'b0));
    tick();
    dev_tld.d_valid = 1'b0;
    h0_d_ready = 1'b1;
    #1;
    chk("tmo_err_stale_off", 128'(stale_drop), 128'(1'b0));
    tick();
    h0_d_ready = 1'b0;
    #1;
    chk("tmo_idle_busy", 128'(busy), 128'(1'b0));
    dev_tld.d_valid = 1'b1;
    #1;
    chk("late_idle_stale", 128'(stale_drop), 128'(1'b1));
    chk("late_idle_dv", 128'({h0_tld.d_valid, h1_tld.d_valid}), 128'(2'b00));
    tick();
    dev_tld.d_valid = 1'b0;
    #1;
    chk("late_idle_stale_off", 128'(stale_drop), 128'(1'b0));

    // ---- reset in RESP abandons the transaction ----
    reset_dut();
    h0_tla = mk_a(1'b1, 3'd4, 8'd7, 32'h80, 32'h0);
    tick();
    h0_tla.a_valid = 1'b0;
    dev_a_ready = 1'b1;
    tick();
    dev_a_ready = 1'b0;
    #1;
    chk("rr_in_resp_busy", 128'(busy), 128'(1'b1));
    rst = 1'b1;
    #1;
    chk("rr_async_busy", 128'(busy), 128'(1'b0));
    tick();
    rst = 1'b0;
    #1;
    chk("rr_after_dv", 128'({h0_tld.d_valid, h1_tld.d_valid}), 128'(2'b00));
    chk("rr_after_ddr", 128'(dev_d_ready), 128'(1'b1));
    h0_tla = mk_a(1'b1, 3'd4, 8'd9, 32'h90, 32'h0);
    h1_tla = mk_a(1'b1, 3'd4, 8'd10, 32'hA0, 32'h0);
    pa = h0_tla;
    #1;
    chk("rr_regrant_ready", 128'({h0_a_ready, h1_a_ready}), 128'(2'b10));
    tick();
    h0_tla.a_valid = 1'b0; h1_tla.a_valid = 1'b0;
    #1;
    chk("rr_regrant_dev_tla", 128'(dev_tla), 128'(fwd_of(pa)));

    // ---- randomized run against the reference model ----
    reset_dut();
    m_active = 1'b0; m_gnt = 1'b0; m_last = 1'b1; m_issued = 1'b0; m_waits = 0; m_pay = '0;
    for (int c = 0; c < 1500; c++) begin
      logic v0, v1, w, err, resp, req, hdr, e_ddr, e_dv0, e_dv1;
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        #1;
        m_active = 1'b0; m_last = 1'b1;
        chk("rnd_reset_busy", 128'(busy), 128'(1'b0));
        tick();
        rst = 1'b0;
      end
      h0_tla = rand_a(); h1_tla = rand_a(); dev_tld = rand_d();
      dev_a_ready = 1'($urandom_range(0, 1));
      h0_d_ready = ($urandom_range(0, 9) < 6);
      h1_d_ready = ($urandom_range(0, 9) < 6);
      #1;
      v0 = h0_tla.a_valid; v1 = h1_tla.a_valid;
      w = (v0 && v1) ? !m_last : v1;
      err = m_active && m_issued && (m_waits >= int'(TO));
      resp = m_active && m_issued && !err;
      req = m_active && !m_issued;
      hdr = m_gnt ? h1_d_ready : h0_d_ready;
      e_ddr = (!m_active || err) ? 1'b1 : (req ? 1'b0 : hdr);
      e_dv0 = (m_gnt == 1'b0) && (err || (resp && dev_tld.d_valid));
      e_dv1 = (m_gnt == 1'b1) && (err || (resp && dev_tld.d_valid));
      chk("rnd_a_ready", 128'({h0_a_ready, h1_a_ready}),
          128'({!m_active && v0 && !w, !m_active && v1 && w}));
      chk("rnd_dev_a_valid", 128'(dev_tla.a_valid), 128'(req));
      chk("rnd_dev_d_ready", 128'(dev_d_ready), 128'(e_ddr));
      chk("rnd_d_valid", 128'({h0_tld.d_valid, h1_tld.d_valid}), 128'({e_dv0, e_dv1}));
      chk("rnd_busy", 128'(busy), 128'(m_active));
      chk("rnd_stale", 128'(stale_drop), 128'(dev_tld.d_valid && (!m_active || err)));
      if (req) chk("rnd_dev_tla", 128'(dev_tla), 128'(fwd_of(m_pay)));
      if (resp || err) begin
        e_d = dev_tld; e_d.d_ready = 1'b0;
        if (err) e_d = err_of(m_pay);
        chk("rnd_host_tld", 128'(m_gnt ? h1_tld : h0_tld), 128'(e_d));
      end
      e_a = w ? h1_tla : h0_tla;
      tick();
      if (!m_active) begin
        if (v0 || v1) begin
          m_active = 1'b1; m_gnt = w; m_last = w; m_pay = e_a; m_issued = 1'b0; m_waits = 0;
        end
      end else if (req) begin
        if (dev_a_ready) begin m_issued = 1'b1; m_waits = 0; end
      end else if (resp) begin
        if (dev_tld.d_valid && hdr) m_active = 1'b0;
        else m_waits++;
      end else if (hdr) begin
        m_active = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tilelink_arbiter_2x1.md
TILELINK_ARBITER_2X1 -- requirements
Module: tilelink_arbiter_2x1

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles spent in RESP without a D handshake before an error response is generated; legal range 1..255.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 h0_tla  in  tilelink_a  host 0 A request; the a_ready field SHALL be ignored.
REQ-005 h0_a_ready  out  1  host 0 A accept.
REQ-006 h0_tld  out  tilelink_d  host 0 D response; the d_ready field SHALL be driven 0.
REQ-007 h0_d_ready  in  1  host 0 D accept.
REQ-008 h1_tla, h1_a_ready, h1_tld, h1_d_ready SHALL be identical to REQ-004..007, for host 1.
REQ-009 dev_tla  out  tilelink_a  device A request; the a_ready field SHALL be driven 0.
REQ-010 dev_a_ready  in  1  device A accept.
REQ-011 dev_tld  in  tilelink_d  device D response; the d_ready field SHALL be ignored.
REQ-012 dev_d_ready  out  1  device D accept.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 stale_drop  out  1  one-cycle pulse when a device D beat is discarded.

Function
REQ-015 The block SHALL have four states: IDLE, REQ, RESP, ERR; at most one transaction SHALL be outstanding.
REQ-016 Register last_grant SHALL select priority: when both hosts have a_valid in IDLE, the host != last_grant SHALL win; a lone valid host SHALL always win.
REQ-017 In IDLE, the winner's a_ready SHALL be asserted combinationally and the loser's SHALL be 0.
REQ-018 On the winner's a_valid & a_ready, the block SHALL latch its full A payload and host index, set last_grant, and go to REQ.
REQ-019 In REQ, dev_tla SHALL present the latched payload with a_valid=1 (first visible one cycle after host acceptance); on dev_a_ready the block SHALL go to RESP.
REQ-020 dev_tla.a_valid SHALL be 0 in every state except REQ; its payload SHALL hold the latched value.
REQ-021 In RESP, the granted host's tld SHALL mirror dev_tld with d_ready=0, the other host's d_valid SHALL be 0, and dev_d_ready SHALL equal the granted host's d_ready.
REQ-022 On the D handshake in RESP, the block SHALL go to IDLE and clear the timeout counter.
REQ-023 An 8-bit timeout counter SHALL increment each RESP cycle without a D handshake; on reaching TIMEOUT_CYCLES it SHALL go to ERR.
REQ-024 In ERR, the granted host's tld SHALL present a synthesized response:
- d_valid=1, d_error=1, d_data=0, d_param=0, d_sink=0
- d_size and d_source from the latched A
- d_opcode AccessAckData (1) if latched a_opcode==Get (4), else AccessAck (0)
REQ-025 In ERR, the block SHALL go to IDLE on the granted host's d_ready.
REQ-026 In IDLE and ERR, dev_d_ready SHALL be 1; any dev_tld.d_valid beat SHALL be discarded and stale_drop pulsed.
REQ-027 In REQ, dev_d_ready SHALL be 0.
REQ-028 Host a_ready SHALL be 0 in REQ, RESP and ERR; host d_valid SHALL be 0 outside RESP and ERR.

Reset
REQ-029 Reset SHALL force:
- state IDLE, last_grant=1, timeout counter 0, latched payload 0
- all outputs 0 except dev_d_ready=1
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no response to either host.

Verification
REQ-031 Both hosts Get at once after reset -> h0 granted; dev_tla.a_valid=1 next cycle; h1 granted after h0's D handshake.
REQ-032 h1 PutFullData addr 0x10 data 0xDEADBEEF, dev_a_ready held 0 for 3 cycles -> dev_tla stable for 4 cycles; then AccessAck routed only to h1.
REQ-033 h0 Get, device silent, TIMEOUT_CYCLES=4 -> ERR after 4 RESP cycles; h0 sees d_opcode=1, d_error=1, d_data=0.
REQ-034 Late device D beat after ERR/IDLE -> stale_drop=1 for one cycle; no host d_valid.
REQ-035 h0 d_ready held 0 while dev_tld valid -> dev_d_ready=0 and state remains RESP until h0 d_ready=1.
REQ-036 Reset asserted in RESP -> next cycle busy=0, all d_valid=0; the next request is granted normally.
